// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, ALU, optional iterative multiplier and the EX/MEM register.
// Define EXEC_MUL_EN to build the 32-step shift-add multiplier; without it MUL returns 0 in one cycle.
module execute_stage #(
   parameter int MUL_CYCLES = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemToRegE,
   input  logic        MemWriteE,
   input  logic        ALUSrcE,
   input  logic        RegDstE,
   input  logic        RegWE,
   input  logic [2:0]  ALUOPE,
   input  logic [31:0] RD1E,
   input  logic [31:0] RD2E,
   input  logic [31:0] SignImmE,
   input  logic [4:0]  RsE,
   input  logic [4:0]  RtE,
   input  logic [4:0]  RdE,
   input  logic [1:0]  ForwardAE,
   input  logic [1:0]  ForwardBE,
   input  logic [31:0] ResultW,
   output logic [4:0]  WriteRegE,
   output logic        busyE,
   output logic        MemToRegM,
   output logic        MemWriteM,
   output logic        RegWM,
   output logic [31:0] ALUOutM,
   output logic [31:0] WriteDataM,
   output logic [4:0]  WriteRegM
);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_NOR = 3'b100;
   localparam logic [2:0] OP_XOR = 3'b101;
   localparam logic [2:0] OP_SLT = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   logic [31:0] src_a;
   logic [31:0] fwd_b;
   logic [31:0] src_b;
   logic [31:0] alu_res;
   logic [31:0] mul_res;
   logic        busy;

   logic        mem_to_reg_q, mem_to_reg_d;
   logic        mem_write_q, mem_write_d;
   logic        reg_w_q, reg_w_d;
   logic [31:0] alu_out_q, alu_out_d;
   logic [31:0] write_data_q, write_data_d;
   logic [4:0]  write_reg_q, write_reg_d;

   // RsE only matters to the hazard unit; MUL_CYCLES is referenced even when the multiplier is absent.
   logic unused_inputs;
   assign unused_inputs = ^{RsE, MUL_CYCLES[0]};

   always_comb begin
      case (ForwardAE)
         2'b01:   src_a = ResultW;
         2'b10:   src_a = alu_out_q;
         default: src_a = RD1E;
      endcase
      case (ForwardBE)
         2'b01:   fwd_b = ResultW;
         2'b10:   fwd_b = alu_out_q;
         default: fwd_b = RD2E;
      endcase
   end

   assign src_b     = ALUSrcE ? SignImmE : fwd_b;
   assign WriteRegE = RegDstE ? RdE : RtE;

   always_comb begin
      case (ALUOPE)
         OP_ADD:  alu_res = src_a + src_b;
         OP_SUB:  alu_res = src_a - src_b;
         OP_AND:  alu_res = src_a & src_b;
         OP_OR:   alu_res = src_a | src_b;
         OP_NOR:  alu_res = ~(src_a | src_b);
         OP_XOR:  alu_res = src_a ^ src_b;
         OP_SLT:  alu_res = {31'd0, $signed(src_a) < $signed(src_b)};
         default: alu_res = mul_res;
      endcase
   end

`ifdef EXEC_MUL_EN
   localparam logic [4:0] LAST_STEP = 5'(MUL_CYCLES - 1);

   typedef enum logic [1:0] {
      MUL_IDLE,
      MUL_BUSY,
      MUL_DONE
   } mul_state_e;

   mul_state_e  state_q, state_d;
   logic [31:0] mcand_q, mcand_d;
   logic [31:0] mplier_q, mplier_d;
   logic [31:0] acc_q, acc_d;
   logic [4:0]  cnt_q, cnt_d;

   // Multiplicand shifts left and multiplier shifts right, so each step only looks at mplier_q[0].
   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      busy     = 1'b0;
      case (state_q)
         MUL_IDLE: begin
            if (ALUOPE == OP_MUL) begin
               busy     = 1'b1;
               mcand_d  = src_a;
               mplier_d = src_b;
               acc_d    = 32'd0;
               cnt_d    = 5'd0;
               state_d  = MUL_BUSY;
            end
         end
         MUL_BUSY: begin
            busy     = 1'b1;
            acc_d    = acc_q + (mplier_q[0] ? mcand_q : 32'd0);
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 5'd1;
            if (cnt_q == LAST_STEP) state_d = MUL_DONE;
         end
         MUL_DONE: state_d = MUL_IDLE;
         default:  state_d = MUL_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= MUL_IDLE;
         mcand_q  <= 32'd0;
         mplier_q <= 32'd0;
         acc_q    <= 32'd0;
         cnt_q    <= 5'd0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
      end
   end

   assign mul_res = acc_q;
`else
   assign busy    = 1'b0;
   assign mul_res = 32'd0;
`endif

   assign busyE = busy;

   // A stalled MUL inserts bubbles: control bits drop, data fields keep their last value.
   always_comb begin
      mem_to_reg_d = 1'b0;
      mem_write_d  = 1'b0;
      reg_w_d      = 1'b0;
      alu_out_d    = alu_out_q;
      write_data_d = write_data_q;
      write_reg_d  = write_reg_q;
      if (!busy) begin
         mem_to_reg_d = MemToRegE;
         mem_write_d  = MemWriteE;
         reg_w_d      = RegWE;
         alu_out_d    = alu_res;
         write_data_d = fwd_b;
         write_reg_d  = WriteRegE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_to_reg_q <= 1'b0;
         mem_write_q  <= 1'b0;
         reg_w_q      <= 1'b0;
         alu_out_q    <= 32'd0;
         write_data_q <= 32'd0;
         write_reg_q  <= 5'd0;
      end else begin
         mem_to_reg_q <= mem_to_reg_d;
         mem_write_q  <= mem_write_d;
         reg_w_q      <= reg_w_d;
         alu_out_q    <= alu_out_d;
         write_data_q <= write_data_d;
         write_reg_q  <= write_reg_d;
      end
   end

   assign MemToRegM  = mem_to_reg_q;
   assign MemWriteM  = mem_write_q;
   assign RegWM      = reg_w_q;
   assign ALUOutM    = alu_out_q;
   assign WriteDataM = write_data_q;
   assign WriteRegM  = write_reg_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage; the MUL scenarios follow whether EXEC_MUL_EN is defined.
module tb_execute_stage;

   logic        clk;
   logic        reset;
   logic        MemToRegE, MemWriteE, ALUSrcE, RegDstE, RegWE;
   logic [2:0]  ALUOPE;
   logic [31:0] RD1E, RD2E, SignImmE, ResultW;
   logic [4:0]  RsE, RtE, RdE;
   logic [1:0]  ForwardAE, ForwardBE;
   logic [4:0]  WriteRegE;
   logic        busyE;
   logic        MemToRegM, MemWriteM, RegWM;
   logic [31:0] ALUOutM, WriteDataM;
   logic [4:0]  WriteRegM;

   int checks = 0;
   int fails  = 0;

   execute_stage dut (
      .clk(clk), .reset(reset),
      .MemToRegE(MemToRegE), .MemWriteE(MemWriteE), .ALUSrcE(ALUSrcE),
      .RegDstE(RegDstE), .RegWE(RegWE), .ALUOPE(ALUOPE),
      .RD1E(RD1E), .RD2E(RD2E), .SignImmE(SignImmE),
      .RsE(RsE), .RtE(RtE), .RdE(RdE),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
      .WriteRegE(WriteRegE), .busyE(busyE),
      .MemToRegM(MemToRegM), .MemWriteM(MemWriteM), .RegWM(RegWM),
      .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .WriteRegM(WriteRegM)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // driver
   task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic alusrc,
                        input logic [1:0] fa, input logic [1:0] fb, input logic [31:0] resw,
                        input logic regdst, input logic [4:0] rt, input logic [4:0] rd,
                        input logic regw, input logic memw, input logic m2r);
      ALUOPE = op; RD1E = a; RD2E = b; SignImmE = imm; ALUSrcE = alusrc;
      ForwardAE = fa; ForwardBE = fb; ResultW = resw;
      RegDstE = regdst; RtE = rt; RdE = rd; RsE = 5'd1;
      RegWE = regw; MemWriteE = memw; MemToRegE = m2r;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(3'b000, 32'd11, 32'd22, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 1'b0, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1);
      #1;
      checks++; if (ALUOutM !== 32'd0) begin fails++; $display("FAIL reset_aluout: got %h want 0", ALUOutM); end
      checks++; if (WriteDataM !== 32'd0) begin fails++; $display("FAIL reset_wdata: got %h want 0", WriteDataM); end
      checks++; if (WriteRegM !== 5'd0) begin fails++; $display("FAIL reset_wreg: got %0d want 0", WriteRegM); end
      checks++; if ({RegWM, MemWriteM, MemToRegM} !== 3'b000) begin fails++; $display("FAIL reset_ctrl: got %b want 000", {RegWM, MemWriteM, MemToRegM}); end
      checks++; if (busyE !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busyE); end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_add();
      @(negedge clk);
      drive(3'b000, 32'd5, 32'd7, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 1'b0, 5'd3, 5'd4, 1'b1, 1'b0, 1'b0);
      @(posedge clk); #1;
      checks++; if (ALUOutM !== 32'd12) begin fails++; $display("FAIL add_result: got %0d want 12", ALUOutM); end
      checks++; if (WriteDataM !== 32'd7) begin fails++; $display("FAIL add_wdata: got %0d want 7", WriteDataM); end
      checks++; if (WriteRegM !== 5'd3) begin fails++; $display("FAIL add_wreg_rt: got %0d want 3", WriteRegM); end
      checks++; if (RegWM !== 1'b1) begin fails++; $display("FAIL add_regw: got %b want 1", RegWM); end
      @(negedge clk);
      drive(3'b000, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 1'b0, 5'd3, 5'd4, 1'b1, 1'b0, 1'b0);
      @(posedge clk); #1;
      checks++; if (ALUOutM !== 32'd1) begin fails++; $display("FAIL add_wrap: got %h want 1", ALUOutM); end
   endtask

   task automatic test_forward_sub();
      @(negedge clk);
      drive(3'b000, 32'd60, 32'd40, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 1'b0, 5'd3, 5'd4, 1'b1, 1'b0, 1'b0);
      @(posedge clk); #1;
      checks++; if (ALUOutM !== 32'd100) begin fails++; $display("FAIL fwd_setup: got %0d want 100", ALUOutM); end
      @(negedge clk);
      drive(3'b001, 32'd999, 32'd888, 32'd0, 1'b0, 2'b10, 2'b01, 32'd30, 1'b0, 5'd3, 5'd4, 1'b1, 1'b0, 1'b0);
      @(posedge clk); #1;
      checks++; if (ALUOutM !== 32'd70) begin fails++; $display("FAIL fwd_sub: got %0d want 70", ALUOutM); end
      checks++; if (WriteDataM !== 32'd30) begin fails++; $display("FAIL fwd_wdata: got %0d want 30", WriteDataM); end
      @(negedge clk);
      drive(3'b001, 32'd10, 32'd3, 32'd0, 1'b0, 2'b11, 2'b11, 32'd500, 1'b0, 5'd3, 5'd4, 1'b1, 1'b0, 1'b0);
      @(posedge clk); #1;
      checks++; if (ALUOutM !== 32'd7) begin fails++; $display("FAIL fwd_sel11: got %0d want 7", ALUOutM); end
      @(negedge clk);
      drive(3'b001, 32'd0, 32'd1, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 1'b0, 5'd3, 5'd4, 1'b1, 1'b0, 1'b0);
      @(posedge clk); #1;
      checks++; if (ALUOutM !== 32'hFFFF_FFFF) begin fails++; $display("FAIL sub_wrap: got %h want ffffffff", ALUOutM); end
   endtask

   task automatic test_slt_imm();
      @(negedge clk);
      drive(3'b110, 32'hFFFF_FFFF, 32'h55, 32'd1, 1'b1, 2'b00, 2'b00, 32'd0, 1'b1, 5'd3, 5'd9, 1'b1, 1'b0, 1'b0);
      #1;
      checks++; if (WriteRegE !== 5'd9) begin fails++; $display("FAIL slt_wrege: got %0d want 9", WriteRegE); end
      @(posedge clk); #1;
      checks++; if (ALUOutM !== 32'd1) begin fails++; $display("FAIL slt_true: got %h want 1", ALUOutM); end
      checks++; if (WriteRegM !== 5'd9) begin fails++; $display("FAIL slt_wregm: got %0d want 9", WriteRegM); end
      checks++; if (WriteDataM !== 32'h55) begin fails++; $display("FAIL slt_wdata: got %h want 55", WriteDataM); end
      @(negedge clk);
      drive(3'b110, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 1'b0, 5'd6, 5'd9, 1'b1, 1'b0, 1'b0);
      #1;
      checks++; if (WriteRegE !== 5'd6) begin fails++; $display("FAIL slt_wrege_rt: got %0d want 6", WriteRegE); end
      @(posedge clk); #1;
      checks++; if (ALUOutM !== 32'd0) begin fails++; $display("FAIL slt_false: got %h want 0", ALUOutM); end
   endtask

   task automatic test_logic();
      logic [2:0]  ops [0:3];
      logic [31:0] exp [0:3];
      ops[0] = 3'b010; exp[0] = 32'h00F0_000F;
      ops[1] = 3'b011; exp[1] = 32'hFFF0_0FFF;
      ops[2] = 3'b100; exp[2] = 32'h000F_F000;
      ops[3] = 3'b101; exp[3] = 32'hFF00_0FF0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         drive(ops[i], 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0,
               1'b1, 5'd2, 5'(20 + i), 1'b0, i[0], i[1]);
         @(posedge clk); #1;
         checks++; if (ALUOutM !== exp[i]) begin fails++; $display("FAIL logic_op%0d: got %h want %h", i, ALUOutM, exp[i]); end
         checks++; if ({RegWM, MemWriteM, MemToRegM, WriteRegM} !== {1'b0, i[0], i[1], 5'(20 + i)}) begin
            fails++; $display("FAIL logic_ctrl%0d: got %b_%b_%b_%0d", i, RegWM, MemWriteM, MemToRegM, WriteRegM);
         end
      end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      drive(3'b000, 32'd300, 32'd45, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 1'b1, 5'd3, 5'd17, 1'b1, 1'b1, 1'b1);
      @(posedge clk); #3;
      reset = 1'b1;
      #1;
      checks++; if ({ALUOutM, WriteDataM, WriteRegM} !== 69'd0) begin fails++; $display("FAIL areset_data: got %h %h %0d want 0", ALUOutM, WriteDataM, WriteRegM); end
      checks++; if ({RegWM, MemWriteM, MemToRegM} !== 3'b000) begin fails++; $display("FAIL areset_ctrl: got %b want 000", {RegWM, MemWriteM, MemToRegM}); end
      @(negedge clk);
      reset = 1'b0;
   endtask

`ifdef EXEC_MUL_EN
   task automatic test_mul();
      logic [31:0] ta [0:1];
      logic [31:0] tb [0:1];
      logic [31:0] te [0:1];
      int busy_cycles, edges, bubble_bad;
      logic was_busy, done;
      ta[0] = 32'd7;         tb[0] = 32'd6; te[0] = 32'd42;
      ta[1] = 32'hFFFF_FFFF; tb[1] = 32'd2; te[1] = 32'hFFFF_FFFE;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         // k=1 is issued right after the DONE edge of k=0: back-to-back with no gap
         drive(3'b111, ta[k], tb[k], 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 1'b1, 5'd3, 5'(10 + k), 1'b1, 1'b0, 1'b0);
         #1;
         busy_cycles = 0; edges = 0; bubble_bad = 0; done = 1'b0;
         while (!done && edges < 40) begin
            was_busy = busyE;
            if (busyE) busy_cycles++;
            if (k == 0 && edges == 5) begin RD1E = 32'd99; ForwardAE = 2'b01; ResultW = 32'd1234; end
            @(posedge clk); #1;
            edges++;
            if (was_busy) begin
               if ({RegWM, MemWriteM, MemToRegM} !== 3'b000) bubble_bad++;
            end else begin
               done = 1'b1;
            end
         end
         checks++; if (done !== 1'b1) begin fails++; $display("FAIL mul%0d_timeout: busy still %b after %0d edges", k, busyE, edges); end
         checks++; if (busy_cycles !== 33) begin fails++; $display("FAIL mul%0d_busy_len: got %0d want 33", k, busy_cycles); end
         checks++; if (edges !== 34) begin fails++; $display("FAIL mul%0d_latency: got %0d edges want 34", k, edges); end
         checks++; if (bubble_bad !== 0) begin fails++; $display("FAIL mul%0d_bubble: %0d busy edges had control set, want 0", k, bubble_bad); end
         checks++; if (ALUOutM !== te[k]) begin fails++; $display("FAIL mul%0d_result: got %h want %h", k, ALUOutM, te[k]); end
         checks++; if (RegWM !== 1'b1) begin fails++; $display("FAIL mul%0d_regw: got %b want 1", k, RegWM); end
         checks++; if (WriteRegM !== 5'(10 + k)) begin fails++; $display("FAIL mul%0d_wreg: got %0d want %0d", k, WriteRegM, 10 + k); end
         checks++; if (WriteDataM !== tb[k]) begin fails++; $display("FAIL mul%0d_wdata: got %h want %h", k, WriteDataM, tb[k]); end
      end
   endtask

   task automatic test_reset_mid_mul();
      @(negedge clk);
      drive(3'b111, 32'd7, 32'd6, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 1'b1, 5'd3, 5'd12, 1'b1, 1'b0, 1'b0);
      repeat (11) @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      checks++; if ({ALUOutM, WriteDataM, WriteRegM} !== 69'd0) begin fails++; $display("FAIL midmul_data: got %h %h %0d want 0", ALUOutM, WriteDataM, WriteRegM); end
      checks++; if ({RegWM, MemWriteM, MemToRegM} !== 3'b000) begin fails++; $display("FAIL midmul_ctrl: got %b want 000", {RegWM, MemWriteM, MemToRegM}); end
      ALUOPE = 3'b000;
      #1;
      checks++; if (busyE !== 1'b0) begin fails++; $display("FAIL midmul_busy_in_reset: got %b want 0", busyE); end
      @(negedge clk);
      reset = 1'b0;
      drive(3'b000, 32'd2, 32'd3, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 1'b1, 5'd3, 5'd13, 1'b1, 1'b0, 1'b0);
      #1;
      checks++; if (busyE !== 1'b0) begin fails++; $display("FAIL midmul_idle_after: busy got %b want 0", busyE); end
      @(posedge clk); #1;
      checks++; if (ALUOutM !== 32'd5) begin fails++; $display("FAIL midmul_add_after: got %0d want 5", ALUOutM); end
      checks++; if (RegWM !== 1'b1) begin fails++; $display("FAIL midmul_regw_after: got %b want 1", RegWM); end
   endtask
`else
   task automatic test_mul_disabled();
      @(negedge clk);
      drive(3'b111, 32'd3, 32'd4, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 1'b0, 5'd8, 5'd2, 1'b1, 1'b0, 1'b0);
      #1;
      checks++; if (busyE !== 1'b0) begin fails++; $display("FAIL nomul_busy_before: got %b want 0", busyE); end
      @(posedge clk); #1;
      checks++; if (ALUOutM !== 32'd0) begin fails++; $display("FAIL nomul_result: got %h want 0", ALUOutM); end
      checks++; if (busyE !== 1'b0) begin fails++; $display("FAIL nomul_busy_after: got %b want 0", busyE); end
      checks++; if ({RegWM, WriteRegM, WriteDataM} !== {1'b1, 5'd8, 32'd4}) begin
         fails++; $display("FAIL nomul_fields: got %b %0d %0d want 1 8 4", RegWM, WriteRegM, WriteDataM);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_add();
      test_forward_sub();
      test_slt_imm();
      test_logic();
      test_async_reset();
`ifdef EXEC_MUL_EN
      test_mul();
      test_reset_mid_mul();
`else
      test_mul_disabled();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
